// File: rtl/impulse_reader_pkg.sv
// Shared widths, read latency and sequencer state encoding for the impulse read path.
package impulse_pkg;
    localparam int WORD_W           = 1024;
    localparam int ADDR_W           = 16;
    localparam int TAP_W            = 16;
    localparam int TAPS_PER_WORD    = 64;
    localparam int RAM_READ_LATENCY = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic [ADDR_W-1:0] index;
        logic              last;
    } word_t;
endpackage

// File: rtl/impulse_reader_word_fifo.sv
// Synchronous word FIFO; the head entry is held in a register and presented directly.
module impulse_word_fifo
    import impulse_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  word_t            i_wr_data,
    input  logic             i_rd_en,
    output word_t            o_rd_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    word_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push, w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push = i_wr_en && (r_count != CNT_W'(DEPTH));
    assign w_pop  = i_rd_en && (r_count != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_valid   = (r_count != '0);
    assign o_count   = r_count;
endmodule

// File: rtl/impulse_reader.sv
// Sweeps the impulse memory once per sample strobe and streams the words, hiding RAM latency.
module impulse_reader
    import impulse_pkg::*;
#(
    parameter int IMPULSE_LENGTH = 750,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              audio_clk,
    input  logic              rst_in,
    input  logic              sample_strobe,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [WORD_W-1:0] read_data,
    output logic [WORD_W-1:0] word_data,
    output logic [ADDR_W-1:0] word_index,
    output logic              word_last,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              sweep_done,
    output logic              overrun
);
    localparam int                CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMPULSE_LENGTH - 1);

    state_t                                r_state, w_next;
    logic [ADDR_W-1:0]                     r_issue_cnt;
    logic                                  r_pending, r_overrun;
    logic [RAM_READ_LATENCY:1]             r_vld_pipe;
    logic [RAM_READ_LATENCY:1][ADDR_W-1:0] r_idx_pipe;
    logic [CNT_W-1:0]                      w_fifo_count;
    logic [CNT_W:0]                        w_used;
    logic                                  w_issue, w_xfer, w_done, w_fifo_valid;
    word_t                                 w_wr_word, w_head;

    // Credits: every read in flight already owns a FIFO slot, so the FIFO can never overflow.
    always_comb begin
        w_used = {1'b0, w_fifo_count};
        for (int i = 1; i <= RAM_READ_LATENCY; i++) w_used = w_used + (CNT_W+1)'(r_vld_pipe[i]);
    end

    assign w_issue = (r_state == ISSUE) && (w_used < (CNT_W+1)'(FIFO_DEPTH));
    assign w_xfer  = w_fifo_valid && word_ready;
    assign w_done  = w_xfer && w_head.last;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sample_strobe) w_next = ISSUE;
            ISSUE:   if (w_issue && r_issue_cnt == LAST_IDX) w_next = DRAIN;
            DRAIN:   if (w_done) w_next = (r_pending || sample_strobe) ? ISSUE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge audio_clk) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_pending   <= 1'b0;
            r_overrun   <= 1'b0;
            r_vld_pipe  <= '0;
            r_idx_pipe  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == ISSUE && r_state != ISSUE) r_issue_cnt <= '0;
            else if (w_issue && r_issue_cnt != LAST_IDX) r_issue_cnt <= r_issue_cnt + ADDR_W'(1);
            r_vld_pipe <= {r_vld_pipe[RAM_READ_LATENCY-1:1], w_issue};
            r_idx_pipe <= {r_idx_pipe[RAM_READ_LATENCY-1:1], r_issue_cnt};
            // A strobe coinciding with the final transfer restarts directly; a queued one is spent here.
            if (w_done) begin
                r_pending <= 1'b0;
                if (sample_strobe && r_pending) r_overrun <= 1'b1;
            end else if (sample_strobe && r_state != IDLE) begin
                if (r_pending) r_overrun <= 1'b1;
                else           r_pending <= 1'b1;
            end
        end
    end

    assign w_wr_word = '{data:  read_data,
                         index: r_idx_pipe[RAM_READ_LATENCY],
                         last:  r_idx_pipe[RAM_READ_LATENCY] == LAST_IDX};

    impulse_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (audio_clk),
        .i_rst_n   (rst_in),
        .i_wr_en   (r_vld_pipe[RAM_READ_LATENCY]),
        .i_wr_data (w_wr_word),
        .i_rd_en   (word_ready),
        .o_rd_data (w_head),
        .o_valid   (w_fifo_valid),
        .o_count   (w_fifo_count)
    );

    assign read_addr  = r_issue_cnt;
    assign word_data  = w_head.data;
    assign word_index = w_head.index;
    assign word_last  = w_head.last;
    assign word_valid = w_fifo_valid;
    assign busy       = (r_state != IDLE);
    assign sweep_done = w_done;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_impulse_reader.sv
// Directed bench: three reader instances (8, 750 and 1 word impulses) fed by 2-cycle RAM models.
module tb_impulse_reader;
    import impulse_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] ram_f(input logic [15:0] a);
        return {32{a ^ 16'hC3A5, a}};
    endfunction

    function automatic logic [63:0] fold(input logic [WORD_W-1:0] d);
        return {d[1023:992], d[31:0]};
    endfunction

    // ---- instance A: IMPULSE_LENGTH = 8
    logic a_strb, a_rdy, a_last, a_valid, a_busy, a_done, a_ovr;
    logic [15:0] a_addr, a_idx;
    logic [WORD_W-1:0] a_rd, a_data, a_q1;
    always @(posedge clk) begin a_q1 <= ram_f(a_addr); a_rd <= a_q1; end
    impulse_reader #(.IMPULSE_LENGTH(8), .FIFO_DEPTH(4)) u_a (
        .audio_clk(clk), .rst_in(rst_n), .sample_strobe(a_strb), .read_addr(a_addr),
        .read_data(a_rd), .word_data(a_data), .word_index(a_idx), .word_last(a_last),
        .word_valid(a_valid), .word_ready(a_rdy), .busy(a_busy), .sweep_done(a_done),
        .overrun(a_ovr));

    // ---- instance B: IMPULSE_LENGTH = 750
    logic b_strb, b_rdy, b_last, b_valid, b_busy, b_done, b_ovr;
    logic [15:0] b_addr, b_idx;
    logic [WORD_W-1:0] b_rd, b_data, b_q1;
    always @(posedge clk) begin b_q1 <= ram_f(b_addr); b_rd <= b_q1; end
    impulse_reader #(.IMPULSE_LENGTH(750), .FIFO_DEPTH(4)) u_b (
        .audio_clk(clk), .rst_in(rst_n), .sample_strobe(b_strb), .read_addr(b_addr),
        .read_data(b_rd), .word_data(b_data), .word_index(b_idx), .word_last(b_last),
        .word_valid(b_valid), .word_ready(b_rdy), .busy(b_busy), .sweep_done(b_done),
        .overrun(b_ovr));

    // ---- instance C: IMPULSE_LENGTH = 1
    logic c_strb, c_rdy, c_last, c_valid, c_busy, c_done, c_ovr;
    logic [15:0] c_addr, c_idx;
    logic [WORD_W-1:0] c_rd, c_data, c_q1;
    always @(posedge clk) begin c_q1 <= ram_f(c_addr); c_rd <= c_q1; end
    impulse_reader #(.IMPULSE_LENGTH(1), .FIFO_DEPTH(4)) u_c (
        .audio_clk(clk), .rst_in(rst_n), .sample_strobe(c_strb), .read_addr(c_addr),
        .read_data(c_rd), .word_data(c_data), .word_index(c_idx), .word_last(c_last),
        .word_valid(c_valid), .word_ready(c_rdy), .busy(c_busy), .sweep_done(c_done),
        .overrun(c_ovr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One or more back-to-back 750-word sweeps on B; s2/s3 are extra strobe cycles (-1 = none).
    task automatic b_run(input string tn, input int total, input bit rnd, input int s2, input int s3);
        int          xf = 0, cyc = 1, dones = 0, busy_gaps = 0, max_used = 0;
        bit          stalled = 1'b0;
        logic [15:0] hold_i = '0;
        logic [63:0] hold_d = '0;
        b_strb = 1'b1;
        b_rdy  = 1'b1;
        tick();
        b_strb = 1'b0;
        while (xf < total && cyc < 20000) begin
            if (stalled) begin
                chk({tn, "_hold_idx"}, b_idx, hold_i);
                chk({tn, "_hold_data"}, fold(b_data), hold_d);
            end
            b_strb = (cyc == s2) || (cyc == s3);
            b_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!b_busy) busy_gaps++;
            if (int'(u_b.w_used) > max_used) max_used = int'(u_b.w_used);
            if (b_valid && b_rdy) begin
                chk($sformatf("%s_idx%0d", tn, xf), b_idx, 64'(xf % 750));
                chk($sformatf("%s_data%0d", tn, xf), fold(b_data), fold(ram_f(16'(xf % 750))));
                chk($sformatf("%s_last%0d", tn, xf), b_last, 64'(xf % 750 == 749));
                chk($sformatf("%s_done%0d", tn, xf), b_done, 64'(xf % 750 == 749));
                if (b_done) dones++;
                xf++;
            end
            stalled = b_valid && !b_rdy;
            hold_i  = b_idx;
            hold_d  = fold(b_data);
            @(posedge clk);
            #1;
            cyc++;
        end
        b_strb = 1'b0;
        chk({tn, "_xfers"}, 64'(xf), 64'(total));
        chk({tn, "_dones"}, 64'(dones), 64'(total / 750));
        chk({tn, "_busy_gaps"}, 64'(busy_gaps), 64'd0);
        chk({tn, "_credit_le4"}, 64'(max_used <= 4), 64'd1);
        chk({tn, "_busy_after"}, b_busy, 64'd0);
    endtask

    initial begin
        int guard;
        rst_n  = 1'b0;
        a_strb = 1'b0; a_rdy = 1'b0;
        b_strb = 1'b0; b_rdy = 1'b0;
        c_strb = 1'b0; c_rdy = 1'b0;
        repeat (3) tick();
        chk("rst_addr", a_addr, 64'd0);
        chk("rst_valid", a_valid, 64'd0);
        chk("rst_data", fold(a_data), 64'd0);
        chk("rst_idx", a_idx, 64'd0);
        chk("rst_last", a_last, 64'd0);
        chk("rst_busy", a_busy, 64'd0);
        chk("rst_done", a_done, 64'd0);
        chk("rst_ovr", a_ovr, 64'd0);
        rst_n = 1'b1;

        // 8-word sweep, ready held high: words in cycles 4..11, busy low in 12
        a_rdy  = 1'b1;
        a_strb = 1'b1;
        tick();
        a_strb = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            if (c == 1) chk("t1_addr_c1", a_addr, 64'd0);
            chk($sformatf("t1_valid_c%0d", c), a_valid, 64'(c >= 4 && c <= 11));
            if (c >= 4 && c <= 11) begin
                chk($sformatf("t1_idx_c%0d", c), a_idx, 64'(c - 4));
                chk($sformatf("t1_data_c%0d", c), fold(a_data), fold(ram_f(16'(c - 4))));
                chk($sformatf("t1_last_c%0d", c), a_last, 64'(c == 11));
            end
            chk($sformatf("t1_done_c%0d", c), a_done, 64'(c == 11));
            chk($sformatf("t1_busy_c%0d", c), a_busy, 64'(c <= 11));
            tick();
        end

        // single-word impulse held under backpressure
        c_strb = 1'b1;
        tick();
        c_strb = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("t5_valid_c%0d", c), c_valid, 64'(c >= 4));
            if (c >= 4) begin
                chk($sformatf("t5_idx_c%0d", c), c_idx, 64'd0);
                chk($sformatf("t5_last_c%0d", c), c_last, 64'd1);
                chk($sformatf("t5_data_c%0d", c), fold(c_data), fold(ram_f(16'd0)));
            end
            chk($sformatf("t5_done_c%0d", c), c_done, 64'd0);
            chk($sformatf("t5_busy_c%0d", c), c_busy, 64'd1);
            tick();
        end
        c_rdy = 1'b1;
        #1;
        chk("t5_done_on_ready", c_done, 64'd1);
        tick();
        chk("t5_valid_after", c_valid, 64'd0);
        chk("t5_busy_after", c_busy, 64'd0);

        // random backpressure over a full 750-word sweep
        b_run("t2", 750, 1'b1, -1, -1);
        chk("t2_overrun", b_ovr, 64'd0);

        // two queued strobes: one pending, one dropped
        b_run("t3", 1500, 1'b0, 100, 200);
        chk("t3_overrun", b_ovr, 64'd1);

        // reset while word 300 waits for the consumer
        b_rdy  = 1'b1;
        b_strb = 1'b1;
        tick();
        b_strb = 1'b0;
        guard  = 0;
        while (!(b_valid && b_idx == 16'd300) && guard < 1000) begin
            tick();
            guard++;
        end
        chk("t4_reached_300", 64'(guard < 1000), 64'd1);
        b_rdy = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t4_valid", b_valid, 64'd0);
        chk("t4_busy", b_busy, 64'd0);
        chk("t4_addr", b_addr, 64'd0);
        chk("t4_ovr", b_ovr, 64'd0);
        rst_n = 1'b1;
        tick();
        b_run("t4", 750, 1'b0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
